seg_scan3: RTL and testbench

- Display back-end for the LED-display path. Consumes the 8-bit count produced by the counting stage (range 0..255, normally 0..32).
- Converts the count to three BCD digits with a sequential double-dabble converter.
- Drives a 3-digit multiplexed common-anode/cathode 7-segment display, with optional leading-zero blanking.

---
 rtl/seg_pkg.sv | 45 ++++
 rtl/bin2bcd_seq.sv | 75 +++++++
 rtl/seg_scan3.sv | 80 ++++++++
 tb/tb_seg_scan3.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 3-digit LED display back-end: segment patterns
// (gfedcba, active-high), converter state encoding and digit slot indices.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] DIG_U = 2'd0;
  localparam logic [1:0] DIG_T = 2'd1;
  localparam logic [1:0] DIG_H = 2'd2;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = SEG_0;
      4'd1:    p = SEG_1;
      4'd2:    p = SEG_2;
      4'd3:    p = SEG_3;
      4'd4:    p = SEG_4;
      4'd5:    p = SEG_5;
      4'd6:    p = SEG_6;
      4'd7:    p = SEG_7;
      4'd8:    p = SEG_8;
      4'd9:    p = SEG_9;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, digits are only
// written in COMMIT so the display never sees a partial result.
//   state     | meaning
//   ST_IDLE   | waiting for value to differ from the last converted value
//   ST_SHIFT  | 8 add-3/shift steps on {acc, shreg}
//   ST_COMMIT | copy accumulator to the displayed digits
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  output logic       busy,
  output logic [3:0] bcd_h,
  output logic [3:0] bcd_t,
  output logic [3:0] bcd_u
);

  state_t      r_state;
  logic [7:0]  r_last_val;
  logic [7:0]  r_shreg;
  logic [11:0] r_acc;
  logic [2:0]  r_bit_cnt;
  logic [11:0] w_adj;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    w_adj = {add3(r_acc[11:8]), add3(r_acc[7:4]), add3(r_acc[3:0])};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_last_val <= 8'd0;
      r_shreg    <= 8'd0;
      r_acc      <= 12'd0;
      r_bit_cnt  <= 3'd0;
      busy       <= 1'b0;
      bcd_h      <= 4'd0;
      bcd_t      <= 4'd0;
      bcd_u      <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (value != r_last_val) begin
            r_shreg    <= value;
            r_last_val <= value;
            r_acc      <= 12'd0;
            r_bit_cnt  <= 3'd0;
            busy       <= 1'b1;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_acc     <= {w_adj[10:0], r_shreg[7]};
          r_shreg   <= {r_shreg[6:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          bcd_h   <= r_acc[11:8];
          bcd_t   <= r_acc[7:4];
          bcd_u   <= r_acc[3:0];
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan3.sv
// 3-digit multiplexed 7-segment driver with leading-zero blanking; the
// converter feeds digits, this block scans slots and registers an/seg.
module seg_scan3
  import seg_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       busy
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_dig_idx;
  logic [3:0]       w_bcd_h, w_bcd_t, w_bcd_u;
  logic             w_wrap;
  logic [1:0]       w_idx_nxt;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic [6:0]       w_pat;
  logic [2:0]       w_an_hi;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .busy  (busy),
    .bcd_h (w_bcd_h),
    .bcd_t (w_bcd_t),
    .bcd_u (w_bcd_u)
  );

  // an/seg are decoded from the slot index that becomes current at this edge
  always_comb begin
    w_wrap    = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
    w_idx_nxt = r_dig_idx;
    if (w_wrap) w_idx_nxt = (r_dig_idx == DIG_H) ? DIG_U : r_dig_idx + 2'd1;
    w_digit = w_bcd_u;
    w_blank = 1'b0;
    case (w_idx_nxt)
      DIG_T: begin
        w_digit = w_bcd_t;
        w_blank = blank_lz && (w_bcd_h == 4'd0) && (w_bcd_t == 4'd0);
      end
      DIG_H: begin
        w_digit = w_bcd_h;
        w_blank = blank_lz && (w_bcd_h == 4'd0);
      end
      default: begin
        w_digit = w_bcd_u;
        w_blank = 1'b0;
      end
    endcase
    w_pat   = w_blank ? SEG_BLANK : seg_decode(w_digit);
    w_an_hi = 3'b001 << w_idx_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
      r_dig_idx <= DIG_U;
      seg       <= SEG_ACTIVE_LOW ? ~SEG_0 : SEG_0;
      an        <= AN_ACTIVE_LOW ? 3'b110 : 3'b001;
    end else begin
      r_div_cnt <= w_wrap ? '0 : r_div_cnt + 1'b1;
      r_dig_idx <= w_idx_nxt;
      seg       <= SEG_ACTIVE_LOW ? ~w_pat : w_pat;
      an        <= AN_ACTIVE_LOW ? ~w_an_hi : w_an_hi;
    end
  end

endmodule

// File: tb/tb_seg_scan3.sv
// Directed bench for seg_scan3 with SCAN_DIV=4 and active-low outputs.
module tb_seg_scan3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] value;
  logic       blank_lz;
  logic [6:0] seg;
  logic [2:0] an;
  logic       busy;

  int n_checks = 0;
  int n_err    = 0;

  seg_scan3 #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // active-low patterns
  localparam logic [6:0] L0 = 7'b1000000, L1 = 7'b1111001, L2 = 7'b0100100,
                         L3 = 7'b0110000, L5 = 7'b0010010, L9 = 7'b0010000,
                         LB = 7'b1111111;

  typedef struct {
    logic [7:0] val;
    logic       blz;
    logic [6:0] su;
    logic [6:0] st;
    logic [6:0] sh;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_scan(input vec_t v);
    repeat (12) begin
      @(negedge clk);
      case (an)
        3'b110:  chk($sformatf("seg_u val=%0d blz=%0d", v.val, v.blz), {25'd0, seg}, {25'd0, v.su});
        3'b101:  chk($sformatf("seg_t val=%0d blz=%0d", v.val, v.blz), {25'd0, seg}, {25'd0, v.st});
        3'b011:  chk($sformatf("seg_h val=%0d blz=%0d", v.val, v.blz), {25'd0, seg}, {25'd0, v.sh});
        default: chk("an_onehot", {29'd0, an}, 32'd6);
      endcase
    end
  endtask

  task automatic wait_busy(input logic lvl, input string nm);
    for (int i = 0; i < 30 && busy !== lvl; i++) @(negedge clk);
    chk(nm, {31'd0, busy}, {31'd0, lvl});
  endtask

  task automatic chk_digits(input string nm, input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    chk(nm, {20'd0, dut.u_conv.bcd_h, dut.u_conv.bcd_t, dut.u_conv.bcd_u}, {20'd0, h, t, u});
  endtask

  initial begin
    logic [2:0] prev_an;
    logic       found;
    logic [2:0] exp_an;

    vecs[0] = '{8'd0,   1'b1, L0, LB, LB};
    vecs[1] = '{8'd255, 1'b0, L5, L5, L2};
    vecs[2] = '{8'd5,   1'b1, L5, LB, LB};
    vecs[3] = '{8'd105, 1'b1, L5, L0, L1};
    vecs[4] = '{8'd5,   1'b1, L5, LB, LB};
    vecs[5] = '{8'd5,   1'b0, L5, L0, L0};
    vecs[6] = '{8'd99,  1'b1, L9, L9, LB};
    vecs[7] = '{8'd100, 1'b1, L0, L0, L1};
    vecs[8] = '{8'd10,  1'b1, L0, L1, LB};
    vecs[9] = '{8'd200, 1'b1, L0, L0, L2};

    rst = 1'b0; value = 8'd0; blank_lz = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_seg",  {25'd0, seg}, {25'd0, L0});
    chk("reset_an",   {29'd0, an}, 32'd6);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    check_scan(vecs[0]);

    // conversion latency 0 -> 32
    @(negedge clk); value = 8'd32; blank_lz = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("lat_busy_hi k=%0d", k), {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk("lat_busy_lo", {31'd0, busy}, 32'd0);
    chk_digits("lat_digits", 4'd0, 4'd3, 4'd2);
    check_scan('{8'd32, 1'b1, L2, L3, LB});

    foreach (vecs[i]) begin
      @(negedge clk); value = vecs[i].val; blank_lz = vecs[i].blz;
      repeat (12) @(negedge clk);
      check_scan(vecs[i]);
    end

    // scan order and slot length at 255
    @(negedge clk); value = 8'd255; blank_lz = 1'b0;
    repeat (12) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      prev_an = an;
      @(negedge clk);
      if (prev_an == 3'b011 && an == 3'b110) found = 1'b1;
    end
    chk("scan_sync", {31'd0, found}, 32'd1);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      exp_an = (k < 4) ? 3'b110 : (k < 8) ? 3'b101 : 3'b011;
      chk($sformatf("scan_an k=%0d", k), {29'd0, an}, {29'd0, exp_an});
    end
    chk_digits("fs_digits", 4'd2, 4'd5, 4'd5);

    // change during a running conversion
    @(negedge clk); value = 8'd17; blank_lz = 1'b1;
    repeat (3) @(negedge clk);
    value = 8'd200;
    wait_busy(1'b0, "mid_first_done");
    chk_digits("mid_first_digits", 4'd0, 4'd1, 4'd7);
    wait_busy(1'b1, "mid_second_start");
    wait_busy(1'b0, "mid_second_done");
    chk_digits("mid_final_digits", 4'd2, 4'd0, 4'd0);
    @(negedge clk);
    check_scan(vecs[9]);

    // async reset in the 4th shift cycle
    @(negedge clk); value = 8'd9; blank_lz = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("areset_seg",  {25'd0, seg}, {25'd0, L0});
    chk("areset_an",   {29'd0, an}, 32'd6);
    chk("areset_busy", {31'd0, busy}, 32'd0);
    chk_digits("areset_digits", 4'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk_digits("post_reset_digits", 4'd0, 4'd0, 4'd9);
    check_scan('{8'd9, 1'b1, L9, LB, LB});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
